// File: rtl/arm_pkg.sv
// Shared ARM pipeline encodings: instruction modes, opcodes, ALU commands,
// condition codes, status-flag positions and the ID control bundle.
package arm_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file: async reset to R[i]=i, one write port,
// two combinational read ports that bypass the in-flight write.
module register_file
  import arm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr1,
  input  logic [AW-1:0]     rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(i);
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // WB writes and ID reads share a cycle, so forward the write data.
  assign rd_data1 = (we && rd_addr1 == wr_addr) ? wr_data : regs[rd_addr1];
  assign rd_data2 = (we && rd_addr2 == wr_addr) ? wr_data : regs[rd_addr2];

endmodule

// File: rtl/id_stage.sv
// ARM instruction-decode stage: field decode, condition check, control
// gating and register-file read. Purely combinational apart from the RF.
module id_stage
  import arm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [31:0]       Instruction,
  input  logic [3:0]        SR,
  input  logic              hazard,
  input  logic              WB_WB_EN,
  input  logic [3:0]        WB_Dest,
  input  logic [DATA_W-1:0] WB_Value,
  output logic [DATA_W-1:0] PC,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic              B,
  output logic              S,
  output logic [3:0]        EXE_CMD,
  output logic [DATA_W-1:0] Val_Rn,
  output logic [DATA_W-1:0] Val_Rm,
  output logic              imm,
  output logic [11:0]       Shift_operand,
  output logic [23:0]       Signed_imm_24,
  output logic [3:0]        Dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              Two_src
);

  logic [3:0] cond;
  logic [1:0] mode;
  logic [3:0] opcode;
  logic       s_bit;
  logic       cond_ok;
  ctrl_t      raw, ctrl;

  assign cond   = Instruction[31:28];
  assign mode   = Instruction[27:26];
  assign opcode = Instruction[24:21];
  assign s_bit  = Instruction[20];

  always_comb begin
    raw = '0;
    case (mode)
      MODE_DP: begin
        raw.s     = s_bit;
        raw.wb_en = 1'b1;
        case (opcode)
          OP_MOV:  raw.exe_cmd = EXE_MOV;
          OP_MVN:  raw.exe_cmd = EXE_MVN;
          OP_ADD:  raw.exe_cmd = EXE_ADD;
          OP_ADC:  raw.exe_cmd = EXE_ADC;
          OP_SUB:  raw.exe_cmd = EXE_SUB;
          OP_SBC:  raw.exe_cmd = EXE_SBC;
          OP_AND:  raw.exe_cmd = EXE_AND;
          OP_ORR:  raw.exe_cmd = EXE_ORR;
          OP_EOR:  raw.exe_cmd = EXE_EOR;
          OP_CMP:  begin raw.exe_cmd = EXE_SUB; raw.wb_en = 1'b0; end
          OP_TST:  begin raw.exe_cmd = EXE_AND; raw.wb_en = 1'b0; end
          default: begin raw.exe_cmd = EXE_NOP; raw.wb_en = 1'b0; end
        endcase
      end
      // S_bit selects LDR (1) versus STR (0); address is always an add.
      MODE_MEM: begin
        raw.exe_cmd  = EXE_ADD;
        raw.mem_r_en = s_bit;
        raw.wb_en    = s_bit;
        raw.mem_w_en = ~s_bit;
      end
      MODE_BR: raw.b = 1'b1;
      default: raw = '0;
    endcase
  end

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok =  SR[SR_Z];
      COND_NE: cond_ok = ~SR[SR_Z];
      COND_CS: cond_ok =  SR[SR_C];
      COND_CC: cond_ok = ~SR[SR_C];
      COND_MI: cond_ok =  SR[SR_N];
      COND_PL: cond_ok = ~SR[SR_N];
      COND_VS: cond_ok =  SR[SR_V];
      COND_VC: cond_ok = ~SR[SR_V];
      COND_HI: cond_ok =  SR[SR_C] & ~SR[SR_Z];
      COND_LS: cond_ok = ~SR[SR_C] |  SR[SR_Z];
      COND_GE: cond_ok =  SR[SR_N] == SR[SR_V];
      COND_LT: cond_ok =  SR[SR_N] != SR[SR_V];
      COND_GT: cond_ok = ~SR[SR_Z] & (SR[SR_N] == SR[SR_V]);
      COND_LE: cond_ok =  SR[SR_Z] | (SR[SR_N] != SR[SR_V]);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // A failed condition or a stall turns the instruction into a bubble.
  assign ctrl = (cond_ok && !hazard) ? raw : '0;

  assign WB_EN    = ctrl.wb_en;
  assign MEM_R_EN = ctrl.mem_r_en;
  assign MEM_W_EN = ctrl.mem_w_en;
  assign B        = ctrl.b;
  assign S        = ctrl.s;
  assign EXE_CMD  = ctrl.exe_cmd;

  assign PC            = PC_in;
  assign imm           = Instruction[25];
  assign Shift_operand = Instruction[11:0];
  assign Signed_imm_24 = Instruction[23:0];
  assign Dest          = Instruction[15:12];

  // Hazard detection needs the true operand set even for bubbled instructions.
  assign src1    = Instruction[19:16];
  assign src2    = raw.mem_w_en ? Instruction[15:12] : Instruction[3:0];
  assign Two_src = (~imm & (mode == MODE_DP)) | raw.mem_w_en;

  register_file #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (WB_WB_EN),
    .wr_addr (WB_Dest),
    .wr_data (WB_Value),
    .rd_addr1(src1),
    .rd_addr2(src2),
    .rd_data1(Val_Rn),
    .rd_data2(Val_Rm)
  );

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed literal checks plus randomized traffic
// compared every cycle against a table-driven behavioural model.
module tb_id_stage;

  logic        clk, rst;
  logic [31:0] PC_in, Instruction, WB_Value;
  logic [3:0]  SR, WB_Dest;
  logic        hazard, WB_WB_EN;
  logic [31:0] PC, Val_Rn, Val_Rm;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, Two_src;
  logic [3:0]  EXE_CMD, Dest, src1, src2;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  logic [31:0] model_r [16];
  int dp_cmd [16];

  id_stage dut (
    .clk(clk), .rst(rst), .PC_in(PC_in), .Instruction(Instruction), .SR(SR),
    .hazard(hazard), .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
    .PC(PC), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S),
    .EXE_CMD(EXE_CMD), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .Dest(Dest),
    .src1(src1), .src2(src2), .Two_src(Two_src)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Data-processing opcode -> ALU command; -1 marks an undefined opcode.
  initial begin
    for (int k = 0; k < 16; k++) dp_cmd[k] = -1;
    dp_cmd[13] = 1; dp_cmd[15] = 9; dp_cmd[4] = 2;  dp_cmd[5] = 3;
    dp_cmd[2]  = 4; dp_cmd[6]  = 5; dp_cmd[0] = 6;  dp_cmd[12] = 7;
    dp_cmd[1]  = 8; dp_cmd[10] = 4; dp_cmd[8] = 6;
  end

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;         1: return !z;
      2: return cy;        3: return !cy;
      4: return n;         5: return !n;
      6: return v;         7: return !v;
      8: return cy && !z;  9: return !cy || z;
      10: return n == v;   11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [3:0] idx);
    return (WB_WB_EN && WB_Dest == idx) ? WB_Value : model_r[idx];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) for (int k = 0; k < 16; k++) model_r[k] = k;
    else if (WB_WB_EN) model_r[WB_Dest] = WB_Value;
  end

  always @(negedge clk) begin
    if (!rst && run) begin
      automatic logic [31:0] i = Instruction;
      automatic int  md = i[27:26];
      automatic int  op = i[24:21];
      automatic bit  sb = i[20];
      automatic bit  go = cond_ok(i[31:28], SR) && !hazard;
      automatic bit  e_wb = 0, e_mr = 0, e_mw = 0, e_b = 0, e_s = 0;
      automatic int  e_cmd = 0;
      automatic bit  str = (md == 1) && !sb;
      automatic logic [3:0] s2 = str ? i[15:12] : i[3:0];
      if (md == 0) begin
        e_s = sb;
        e_cmd = dp_cmd[op] < 0 ? 0 : dp_cmd[op];
        e_wb = dp_cmd[op] >= 0 && op != 10 && op != 8;
      end else if (md == 1) begin
        e_cmd = 2; e_mr = sb; e_wb = sb; e_mw = !sb;
      end else if (md == 2) begin
        e_b = 1;
      end
      if (!go) begin
        e_wb = 0; e_mr = 0; e_mw = 0; e_b = 0; e_s = 0; e_cmd = 0;
      end
      chk("PC", PC, PC_in);
      chk("WB_EN", WB_EN, e_wb);
      chk("MEM_R_EN", MEM_R_EN, e_mr);
      chk("MEM_W_EN", MEM_W_EN, e_mw);
      chk("B", B, e_b);
      chk("S", S, e_s);
      chk("EXE_CMD", EXE_CMD, e_cmd);
      chk("imm", imm, i[25]);
      chk("Shift_operand", Shift_operand, i[11:0]);
      chk("Signed_imm_24", Signed_imm_24, i[23:0]);
      chk("Dest", Dest, i[15:12]);
      chk("src1", src1, i[19:16]);
      chk("src2", src2, s2);
      chk("Two_src", Two_src, (!i[25] && md == 0) || str);
      chk("Val_Rn", Val_Rn, rd(i[19:16]));
      chk("Val_Rm", Val_Rm, rd(s2));
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [3:0] sr, input logic hz,
                       input logic we, input logic [3:0] wd, input logic [31:0] wv);
    Instruction = ins; SR = sr; hazard = hz;
    WB_WB_EN = we; WB_Dest = wd; WB_Value = wv;
    PC_in = $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1;
    drive(32'h0, 4'h0, 0, 0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    run = 1;

    drive(32'hE1A0_0001, 4'h0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    chk("reset_Val_Rm", Val_Rm, 32'h1);
    chk("mov_EXE_CMD", EXE_CMD, 32'h1);
    chk("mov_WB_EN", WB_EN, 32'h1);
    chk("mov_Dest", Dest, 32'h0);
    chk("mov_Two_src", Two_src, 32'h1);

    next_cycle();
    drive(32'hE1A0_0001, 4'h0, 0, 1, 4'h3, 32'hDEAD_BEEF);
    next_cycle();
    drive(32'hE083_2003, 4'h0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    chk("wr_Val_Rn", Val_Rn, 32'hDEAD_BEEF);
    chk("wr_Val_Rm", Val_Rm, 32'hDEAD_BEEF);
    chk("add_EXE_CMD", EXE_CMD, 32'h2);

    next_cycle();
    drive(32'hE085_1000, 4'h0, 0, 1, 4'h5, 32'h1234);
    @(negedge clk);
    chk("bypass_Val_Rn", Val_Rn, 32'h1234);

    next_cycle();
    drive(32'h1280_1001, 4'h4, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    chk("ne_fail_WB_EN", WB_EN, 32'h0);
    chk("ne_fail_EXE_CMD", EXE_CMD, 32'h0);
    next_cycle();
    drive(32'h1280_1001, 4'h0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    chk("ne_pass_WB_EN", WB_EN, 32'h1);
    chk("ne_pass_EXE_CMD", EXE_CMD, 32'h2);

    next_cycle();
    drive(32'hE581_2004, 4'h0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    chk("str_MEM_W_EN", MEM_W_EN, 32'h1);
    chk("str_src2", src2, 32'h2);
    chk("str_Two_src", Two_src, 32'h1);
    chk("str_WB_EN", WB_EN, 32'h0);
    next_cycle();
    drive(32'hE591_2004, 4'h0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    chk("ldr_MEM_R_EN", MEM_R_EN, 32'h1);
    chk("ldr_WB_EN", WB_EN, 32'h1);
    next_cycle();
    drive(32'hEAFF_FFFE, 4'h0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    chk("b_B", B, 32'h1);
    chk("b_imm24", Signed_imm_24, 32'hFF_FFFE);

    next_cycle();
    drive(32'hE083_2003, 4'h0, 1, 0, 4'h0, 32'h0);
    @(negedge clk);
    chk("hz_WB_EN", WB_EN, 32'h0);
    chk("hz_EXE_CMD", EXE_CMD, 32'h0);
    chk("hz_src1", src1, 32'h3);
    chk("hz_src2", src2, 32'h3);
    chk("hz_Val_Rn", Val_Rn, 32'hDEAD_BEEF);

    // Mid-run reset must restore R3 to its reset value immediately.
    next_cycle();
    drive(32'hE083_2003, 4'h0, 0, 0, 4'h0, 32'h0);
    rst = 1;
    @(negedge clk);
    chk("midrst_Val_Rn", Val_Rn, 32'h3);
    chk("midrst_R5", model_r[5], 32'h5);
    next_cycle();
    rst = 0;

    for (int n = 0; n < 3000; n++) begin
      automatic logic [31:0] ins = $urandom;
      if ($urandom_range(3) != 0) ins[31:28] = 4'hE;
      drive(ins, 4'($urandom), ($urandom_range(7) == 0), 1'($urandom),
            4'($urandom), $urandom);
      next_cycle();
    end

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
